// File: rtl/druaga_pkg.sv
// Shared types and constants for the Druaga per-scanline sprite scheduler.
package druaga_pkg;

  localparam logic [8:0] Y_BIAS     = 9'd16;
  localparam logic [8:0] MASK_TALL  = 9'h1E0;
  localparam logic [8:0] MASK_SHORT = 9'h1F0;

  // Render descriptor handed to the line-buffer renderer (30 bits).
  typedef struct packed {
    logic [7:0] code;
    logic [4:0] row;
    logic [5:0] pal;
    logic [8:0] x;
    logic       wide;
    logic       hflip;
  } desc_t;

  localparam int unsigned DESC_W = $bits(desc_t);

  typedef enum logic [2:0] {IDLE, ADDR0, EVAL0, EVAL1, NEXT} state_t;

endpackage

// File: rtl/druaga_sprite_scheduler_if.sv
// Scheduler bus: line control, sprite RAM port and descriptor stream.
interface druaga_sprite_scheduler_if;
  import druaga_pkg::*;

  logic       line_start;
  logic [8:0] vpos;
  logic [6:0] spra_a;
  logic [23:0] spra_d;
  logic       desc_valid;
  logic       desc_ready;
  desc_t      desc;
  logic       busy;
  logic       ovf;

  modport master (
    input  line_start, vpos, spra_d, desc_ready,
    output spra_a, desc_valid, desc, busy, ovf
  );

  modport slave (
    output line_start, vpos, spra_d, desc_ready,
    input  spra_a, desc_valid, desc, busy, ovf
  );
endinterface

// File: rtl/sprite_desc_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
module sprite_desc_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop frees the slot this cycle, so a full FIFO may still accept.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (!push_ok && pop_ok) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/druaga_sprite_scheduler.sv
// Scans sprite attribute RAM each line and queues render descriptors for hits on the next line.
module druaga_sprite_scheduler
  import druaga_pkg::*;
#(
  parameter int unsigned QDEPTH = 16,
  parameter int unsigned NSPR   = 64,
  parameter logic [8:0]  XOFS   = 9'h38
) (
  input  logic                       vclk,
  input  logic                       reset,
  druaga_sprite_scheduler_if.master  bus
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  state_t     state, state_d;
  logic [5:0] n, n_d;
  logic [8:0] vline, vline_d;
  logic [7:0] code, code_d;
  logic [4:0] row, row_d;
  logic       wide, wide_d, hflip, hflip_d;
  logic       phase, phase_d;
  logic [6:0] spra_a, spra_a_d;
  logic       ovf, ovf_d, busy, busy_d;

  logic             push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  desc_t            push_desc;

  logic       tall0, wide0, vflip0, hflip0, hit;
  logic [8:0] y, m, x_calc;
  logic [4:0] rmask;
  logic       unused_bits;

  // Word-0 decode is valid in EVAL0, word-1 decode in the second EVAL1 cycle.
  assign tall0  = bus.spra_d[19];
  assign wide0  = bus.spra_d[18];
  assign vflip0 = bus.spra_d[17];
  assign hflip0 = bus.spra_d[16];
  assign y      = 9'(bus.spra_d[15:8]) + Y_BIAS + vline;
  assign m      = tall0 ? MASK_TALL : MASK_SHORT;
  assign hit    = ((y & m) == {1'b0, m[7:0]});
  assign rmask  = {tall0, 4'hF};
  assign x_calc = {bus.spra_d[16], bus.spra_d[15:8]} - XOFS;
  assign unused_bits = ^bus.spra_d[23:20];

  assign pop = bus.desc_ready && !fifo_empty && !bus.line_start;

  always_comb begin
    push_desc.code  = code;
    push_desc.row   = row;
    push_desc.pal   = bus.spra_d[5:0];
    push_desc.x     = x_calc;
    push_desc.wide  = wide;
    push_desc.hflip = hflip;
  end

  always_ff @(posedge vclk) begin
    if (reset) begin
      state  <= IDLE;
      n      <= '0;
      vline  <= '0;
      code   <= '0;
      row    <= '0;
      wide   <= 1'b0;
      hflip  <= 1'b0;
      phase  <= 1'b0;
      spra_a <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      n      <= n_d;
      vline  <= vline_d;
      code   <= code_d;
      row    <= row_d;
      wide   <= wide_d;
      hflip  <= hflip_d;
      phase  <= phase_d;
      spra_a <= spra_a_d;
      ovf    <= ovf_d;
      busy   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    n_d      = n;
    vline_d  = vline;
    code_d   = code;
    row_d    = row;
    wide_d   = wide;
    hflip_d  = hflip;
    phase_d  = phase;
    spra_a_d = spra_a;
    ovf_d    = ovf;
    push     = 1'b0;

    if (bus.line_start) begin
      vline_d  = bus.vpos + 9'd1;
      ovf_d    = 1'b0;
      n_d      = '0;
      phase_d  = 1'b0;
      spra_a_d = '0;
      state_d  = ADDR0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR0: begin
          spra_a_d = {n, 1'b0};
          state_d  = EVAL0;
        end
        EVAL0: begin
          if (hit) begin
            code_d   = bus.spra_d[7:0] & {6'h3F, ~tall0, ~wide0};
            row_d    = (y[4:0] & rmask) ^ (vflip0 ? rmask : 5'd0);
            wide_d   = wide0;
            hflip_d  = hflip0;
            spra_a_d = {n, 1'b1};
            phase_d  = 1'b0;
            state_d  = EVAL1;
          end else begin
            state_d = NEXT;
          end
        end
        // First EVAL1 cycle waits for the word-1 read to return.
        EVAL1: begin
          if (!phase) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            push    = !bus.spra_d[17];
            if (push && fifo_full && !pop) ovf_d = 1'b1;
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (n == 6'(NSPR - 1)) begin
            state_d = IDLE;
          end else begin
            n_d      = n + 6'd1;
            spra_a_d = {n + 6'd1, 1'b0};
            state_d  = ADDR0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.spra_a     = spra_a;
  assign bus.busy       = busy;
  assign bus.ovf        = ovf;
  assign bus.desc_valid = (fifo_count != '0);

  sprite_desc_fifo #(.WIDTH(DESC_W), .DEPTH(QDEPTH)) u_fifo (
    .clk   (vclk),
    .reset (reset),
    .flush (bus.line_start),
    .push  (push),
    .pop   (pop),
    .wdata (push_desc),
    .rdata (bus.desc),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule
